// File: rtl/seq_div_pkg.sv
// seq_div_pkg: state encoding and sizing helpers shared by the sequential divider
package seq_div_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
   localparam int DEF_WIDTH = 8;
   function automatic int cnt_width(input int w);
      return $clog2(w + 1);
   endfunction
endpackage

// File: rtl/seq_div_sub_slice.sv
// seq_div_sub_slice: N-bit ripple subtractor a-b as full adders on ~b with carry-in 1
module seq_div_sub_slice #(
   parameter int N = 9
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic [N-1:0] diff,
   output logic         borrow
);
   logic [N:0] c;
   assign c[0] = 1'b1;
   for (genvar i = 0; i < N; i++) begin : g_fa
      assign diff[i]  = a[i] ^ ~b[i] ^ c[i];
      assign c[i+1]   = (a[i] & ~b[i]) | (c[i] & (a[i] ^ ~b[i]));
   end
   assign borrow = ~c[N];
endmodule

// File: rtl/seq_div.sv
// seq_div: restoring shift-subtract divider, 2W/W -> W quotient + W remainder, one bit per clock
// Optional SEQ_DIV_OVF_CHECK_EN: zero-divisor / quotient-overflow fast path flagged on err.
module seq_div
   import seq_div_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [2*WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0]   divisor,
   output logic [WIDTH-1:0]   quot,
   output logic [WIDTH-1:0]   rem,
   output logic               busy,
   output logic               done,
   output logic               err
);
   localparam int CW = cnt_width(WIDTH);
   state_t state, state_nx;
   logic [WIDTH-1:0] r, q, d, r_sh, r_nx, q_nx, diff;
   logic [CW-1:0] cnt;
   logic diff_unused, borrow, last, bad, accept;
   assign r_sh   = {r[WIDTH-2:0], q[WIDTH-1]};
   assign q_nx   = {q[WIDTH-2:0], ~borrow};
   assign r_nx   = borrow ? r_sh : diff;
   assign last   = cnt == CW'(WIDTH - 1);
   assign accept = state == IDLE && start;
   assign busy   = state == RUN;
   assign done   = state == DONE;
`ifdef SEQ_DIV_OVF_CHECK_EN
   assign bad = divisor == '0 || dividend[2*WIDTH-1:WIDTH] >= divisor;
`else
   assign bad = 1'b0;
`endif
   seq_div_sub_slice #(.N(WIDTH + 1)) u_sub (
      .a      ({r[WIDTH-1], r_sh}),
      .b      ({1'b0, d}),
      .diff   ({diff_unused, diff}),
      .borrow (borrow)
   );
   // state register
   always_ff @(posedge clk or negedge reset)
      if (!reset) state <= IDLE;
      else state <= state_nx;
   // next state: accept from IDLE (fast path on bad operands), WIDTH iterations in RUN, one DONE cycle
   always_comb begin
      state_nx = state == IDLE ? (start ? (bad ? DONE : RUN) : IDLE) :
                 state == RUN  ? (last ? DONE : RUN) : IDLE;
   end
   // operand capture, shift-subtract iteration and result registers
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         r    <= '0;
         q    <= '0;
         d    <= '0;
         cnt  <= '0;
         quot <= '0;
         rem  <= '0;
         err  <= 1'b0;
      end else if (accept) begin
         r   <= dividend[2*WIDTH-1:WIDTH];
         q   <= dividend[WIDTH-1:0];
         d   <= divisor;
         cnt <= '0;
         if (bad) begin
            quot <= '1;
            rem  <= '0;
            err  <= 1'b1;
         end
      end else if (state == RUN) begin
         r   <= r_nx;
         q   <= q_nx;
         cnt <= cnt + 1'b1;
         if (last) begin
            quot <= q_nx;
            rem  <= r_nx;
            err  <= 1'b0;
         end
      end
endmodule

// File: tb/tb_seq_div.sv
// tb_seq_div: scoreboard bench for seq_div against a plain-arithmetic division model
module tb_seq_div;
   localparam int W = 8;
   logic clk = 0, reset = 1, start = 0;
   logic [2*W-1:0] dividend = '0;
   logic [W-1:0] divisor = '0, quot, rem;
   logic busy, done, err;
   int n_cmp = 0, n_bad = 0, cyc = 0, busy_run = 0;
   bit prev_done = 0;
   typedef struct {
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         e;
      int           lat;
      int           acc;
      bit           chk_qr;
   } exp_t;
   exp_t sbq[$];

   seq_div #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset), .start(start), .dividend(dividend), .divisor(divisor),
      .quot(quot), .rem(rem), .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // monitor: pops the scoreboard whenever done is presented
   always @(negedge clk) begin
      exp_t e;
      if (!reset) begin
         busy_run = 0;
         prev_done = 0;
      end else begin
         if (prev_done) check("done_one_cycle", done, 0);
         if (done) begin
            if (sbq.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_done: got done=1 expected no pending op");
            end else begin
               e = sbq.pop_front();
               check("err", err, e.e);
               check("latency", cyc - e.acc, e.lat);
               check("busy_cycles", busy_run, e.lat == 1 ? 0 : W);
               check("busy_at_done", busy, 0);
               if (e.chk_qr) begin
                  check("quot", quot, e.q);
                  check("rem", rem, e.r);
               end
            end
            busy_run = 0;
         end else if (busy) busy_run++;
         prev_done = done;
      end
   end

   task automatic do_op(input logic [2*W-1:0] dd, input logic [W-1:0] dv, input bit pester);
      exp_t e;
      bit bad = 0;
`ifdef SEQ_DIV_OVF_CHECK_EN
      bad = dv == 0 || dd[2*W-1:W] >= dv;
`endif
      e.e = bad;
      e.lat = bad ? 1 : W;
      e.chk_qr = bad || (dv != 0 && dd[2*W-1:W] < dv);
      e.q = '1;
      e.r = '0;
      if (!bad && e.chk_qr) begin
         e.q = W'(dd / dv);
         e.r = W'(dd % dv);
      end
      @(negedge clk);
      dividend = dd;
      divisor = dv;
      start = 1;
      @(posedge clk);
      #1;
      e.acc = cyc;
      sbq.push_back(e);
      start = 0;
      dividend = 16'($urandom);
      divisor = 8'($urandom);
      if (pester && !bad) begin
         repeat (3) @(negedge clk);
         start = 1;
         @(negedge clk);
         start = 0;
         repeat (4) @(negedge clk);
         start = 1;
         @(negedge clk);
         start = 0;
      end
      for (int i = 0; i < 4 * W && !done; i++) @(negedge clk);
      if (!done) begin
         n_cmp++;
         n_bad++;
         $display("FAIL done_timeout: got done=0 expected done within %0d cycles", 4 * W);
         sbq.delete();
      end
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish before time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [W-1:0] dv, hi;
      #2 reset = 0;
      #1;
      check("rst_quot", quot, 0);
      check("rst_rem", rem, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      repeat (3) @(negedge clk);
      reset = 1;
      do_op(16'h0064, 8'h07, 0);
      repeat (3) @(negedge clk);
      check("hold_quot", quot, 8'h0E);
      check("hold_rem", rem, 8'h02);
      do_op(16'h1234, 8'h56, 0);
      do_op(16'hFE01, 8'hFF, 0);
      do_op(16'h0064, 8'h07, 1);
      check("idle_after_ignored_start", busy, 0);
      @(negedge clk);
      dividend = 16'h1234;
      divisor = 8'h56;
      start = 1;
      @(posedge clk);
      #1 start = 0;
      repeat (4) @(negedge clk);
      #2 reset = 0;
      #1;
      check("abort_quot", quot, 0);
      check("abort_rem", rem, 0);
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_err", err, 0);
      repeat (2) @(negedge clk);
      reset = 1;
      repeat (W + 4) @(negedge clk);
      do_op(16'h0064, 8'h07, 0);
      do_op(16'h0100, 8'h00, 0);
      do_op(16'hFFFF, 8'hFF, 0);
      do_op(16'h0064, 8'h07, 0);
      for (int i = 0; i < 30; i++) begin
         dv = 8'($urandom_range(1, 255));
         hi = 8'($urandom_range(0, int'(dv) - 1));
         do_op({hi, 8'($urandom)}, dv, i % 7 == 0);
      end
      for (int i = 0; i < 10; i++) begin
         dv = $urandom_range(0, 3) == 0 ? 8'h00 : 8'($urandom);
         do_op(16'($urandom), dv, 0);
      end
      check("scoreboard_empty", sbq.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
